// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg -- shared helpers for the UART receiver.
//   cnt_width(n): bit width needed to hold the value n-1, with a minimum of 1.
package uart_rx_pkg;

   function automatic int cnt_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/uart_rx_synchronizer.sv
// synchronizer -- two-flop synchronizer for a single asynchronous bit.
//   clk   : sampling clock
//   rst   : synchronous active-high reset, loads RST_VAL into both flops
//   d     : asynchronous input
//   q     : synchronized output, two clk edges behind d
module synchronizer #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver with data-ready handshake.
//   clk       : clock, everything on the rising edge
//   rst       : synchronous active-high reset
//   rx        : asynchronous serial line, idle high
//   go        : consumer acknowledge pulse, clears dr and overrun
//   data      : last received byte
//   dr        : data ready, held until go
//   frame_err : one-cycle pulse when the stop bit reads low
//   overrun   : sticky, set when a byte arrives while dr is still high
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int CLK_FREQ  = 10_125_000,
   parameter int BAUD_RATE = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       go,
   output logic [7:0] data,
   output logic       dr,
   output logic       frame_err,
   output logic       overrun
);

   localparam int BIT_TIME = CLK_FREQ / BAUD_RATE;
   localparam int HALF     = BIT_TIME / 2;
   localparam int CW       = cnt_width(BIT_TIME);

   localparam logic [CW-1:0] BT_M1   = CW'(BIT_TIME - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_STOP      = 3'd3;
   localparam logic [2:0] S_WAIT_HIGH = 3'd4;

   logic          rxs;
   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          dr_q, dr_d;
   logic          frame_err_q, frame_err_d;
   logic          overrun_q, overrun_d;
   logic          phase_end;
   logic          byte_done;

   // Line idles high, so the synchronizer resets to 1 to avoid a fake start bit.
   synchronizer #(.RST_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rxs)
   );

   assign phase_end = (cnt_q == '0);

   // State register and datapath flops
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         dr_q        <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         dr_q        <= dr_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (!rxs) state_d = S_START;
         S_START:     if (phase_end) state_d = rxs ? S_IDLE : S_DATA;
         S_DATA:      if (phase_end && bit_idx_q == 3'd7) state_d = S_STOP;
         S_STOP:      if (phase_end) state_d = rxs ? S_IDLE : S_WAIT_HIGH;
         S_WAIT_HIGH: if (rxs) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   assign byte_done = (state_q == S_STOP) && phase_end && rxs;

   // Counter, shifter and output logic
   always_comb begin
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      data_d      = data_q;
      dr_d        = dr_q;
      overrun_d   = overrun_q;
      frame_err_d = 1'b0;

      // Counter only ever decrements inside a timed phase and stops at 0.
      if (state_q == S_START || state_q == S_DATA || state_q == S_STOP) begin
         if (!phase_end) cnt_d = cnt_q - 1'b1;
      end

      case (state_q)
         S_IDLE: if (!rxs) cnt_d = HALF_M1;
         S_START: if (phase_end && !rxs) begin
            cnt_d     = BT_M1;
            bit_idx_d = '0;
         end
         S_DATA: if (phase_end) begin
            shift_d   = {rxs, shift_q[7:1]};
            cnt_d     = BT_M1;
            bit_idx_d = bit_idx_q + 3'd1;
         end
         S_STOP: if (phase_end && !rxs) frame_err_d = 1'b1;
         default: ;
      endcase

      if (go && dr_q) begin
         dr_d      = 1'b0;
         overrun_d = 1'b0;
      end

      // A same-cycle go frees the slot, so the new byte wins over overrun.
      if (byte_done) begin
         if (!dr_q || go) begin
            data_d    = shift_q;
            dr_d      = 1'b1;
            overrun_d = 1'b0;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   assign data      = data_q;
   assign dr        = dr_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed bench for uart_rx at BIT_TIME=10, HALF=5.
module tb_uart_rx;

   logic       clk;
   logic       rst;
   logic       rx;
   logic       go;
   logic [7:0] data;
   logic       dr;
   logic       frame_err;
   logic       overrun;

   int ncmp  = 0;
   int nfail = 0;
   int cyc   = 0;
   int base  = 0;
   int dr_rise = -1;
   int fe_cnt  = 0;
   logic dr_prev = 1'b0;
   logic [10:0] rst_snap = '0;

   uart_rx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .go        (go),
      .data      (data),
      .dr        (dr),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock edge, then sample outputs 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (frame_err === 1'b1) fe_cnt++;
      if (dr === 1'b1 && dr_prev !== 1'b1) dr_rise = cyc - base;
      dr_prev = dr;
   endtask

   task automatic idle(input int n, input logic lvl);
      for (int k = 0; k < n; k++) begin
         rx = lvl;
         tick();
      end
   endtask

   // Drive one 100-cycle frame. go_tick/rst_tick: edge index (1-based from
   // the start bit) that sees go/rst high; 0 means never.
   task automatic send(input logic [7:0] b, input logic stop, input int go_tick,
                       input int rst_tick);
      logic [9:0] bits;
      bits    = {stop, b, 1'b0};
      base    = cyc;
      dr_rise = -1;
      for (int i = 0; i < 100; i++) begin
         rx  = bits[i/10];
         go  = (i + 1 == go_tick);
         rst = (i + 1 == rst_tick);
         tick();
         if (i + 1 == rst_tick) rst_snap = {data, dr, frame_err, overrun};
      end
      go  = 1'b0;
      rst = 1'b0;
   endtask

   task automatic pulse_go();
      go = 1'b1;
      tick();
      go = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      rx  = 1'b1;
      go  = 1'b0;
      tick();
      tick();
      chk("rst_data", 32'(data), 32'h00);
      chk("rst_dr", 32'(dr), 32'h0);
      chk("rst_fe", 32'(frame_err), 32'h0);
      chk("rst_ov", 32'(overrun), 32'h0);
      rst = 1'b0;
      idle(5, 1'b1);

      // Clean frame 0xA5: dr rises 1+HALF+9*BIT_TIME after rxs first low,
      // which is edge 98 counted from the rx falling edge.
      fe_cnt = 0;
      send(8'hA5, 1'b1, 0, 0);
      chk("a5_data", 32'(data), 32'hA5);
      chk("a5_dr", 32'(dr), 32'h1);
      chk("a5_latency", 32'(dr_rise), 32'd98);
      chk("a5_fe", 32'(fe_cnt), 32'd0);
      pulse_go();
      chk("a5_go_dr", 32'(dr), 32'h0);

      // Glitch: 3 low cycles aborts in START.
      fe_cnt = 0;
      base = cyc;
      dr_rise = -1;
      idle(3, 1'b0);
      idle(20, 1'b1);
      chk("glitch_dr", 32'(dr), 32'h0);
      chk("glitch_rise", 32'(dr_rise), 32'hFFFFFFFF);
      chk("glitch_fe", 32'(fe_cnt), 32'd0);
      chk("glitch_data", 32'(data), 32'hA5);

      // Bad stop bit then line held low: one frame_err pulse, no restart.
      fe_cnt = 0;
      send(8'h3C, 1'b0, 0, 0);
      idle(30, 1'b0);
      chk("fe_count", 32'(fe_cnt), 32'd1);
      chk("fe_dr", 32'(dr), 32'h0);
      chk("fe_data", 32'(data), 32'hA5);
      idle(5, 1'b1);
      send(8'h55, 1'b1, 0, 0);
      chk("after_fe_data", 32'(data), 32'h55);
      chk("after_fe_rise", 32'(dr_rise), 32'd98);
      chk("after_fe_count", 32'(fe_cnt), 32'd1);
      pulse_go();

      // Overrun: second byte dropped, flag sticky until go.
      send(8'h11, 1'b1, 0, 0);
      send(8'h22, 1'b1, 0, 0);
      chk("ov_data", 32'(data), 32'h11);
      chk("ov_dr", 32'(dr), 32'h1);
      chk("ov_flag", 32'(overrun), 32'h1);
      idle(7, 1'b1);
      chk("ov_sticky", 32'(overrun), 32'h1);
      pulse_go();
      chk("ov_go_dr", 32'(dr), 32'h0);
      chk("ov_go_flag", 32'(overrun), 32'h0);
      pulse_go();
      chk("go_idle_dr", 32'(dr), 32'h0);
      chk("go_idle_data", 32'(data), 32'h11);

      // go on the completion edge of the second byte: new byte loads.
      send(8'h11, 1'b1, 0, 0);
      send(8'h22, 1'b1, 98, 0);
      chk("race_data", 32'(data), 32'h22);
      chk("race_dr", 32'(dr), 32'h1);
      chk("race_ov", 32'(overrun), 32'h0);

      // Reset mid-frame during data bit 4 of 0xFF.
      send(8'hFF, 1'b1, 0, 56);
      chk("rst_mid_snap", 32'(rst_snap), 32'h0);
      chk("rst_mid_dr", 32'(dr), 32'h0);
      chk("rst_mid_data", 32'(data), 32'h00);
      chk("rst_mid_rise", 32'(dr_rise), 32'hFFFFFFFF);
      idle(5, 1'b1);
      send(8'h81, 1'b1, 0, 0);
      chk("post_rst_data", 32'(data), 32'h81);
      chk("post_rst_dr", 32'(dr), 32'h1);
      chk("post_rst_rise", 32'(dr_rise), 32'd98);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL take parameter CLK_FREQ, default 10_125_000, the clock frequency in Hz.
REQ-002 The block SHALL take parameter BAUD_RATE, default 9600, the line bit rate.
REQ-003 The block SHALL use derived constants BIT_TIME = CLK_FREQ/BAUD_RATE (integer division) and HALF = BIT_TIME/2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-007 The block SHALL have port go, input, 1 bit: consumer acknowledge, one-cycle pulse.
REQ-008 The block SHALL have port data, output, 8 bits: last received byte.
REQ-009 The block SHALL have port dr, output, 1 bit: data ready.
REQ-010 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-011 The block SHALL have port overrun, output, 1 bit: sticky lost-byte flag.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; all sampling SHALL use the synchronized value rxs.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-014 Phase timing: a phase loads the bit counter with N-1 and ends when the counter reaches 0, so each phase lasts exactly N cycles.
REQ-015 IDLE: if rxs=0 in cycle t, the FSM SHALL enter START in t+1 with counter HALF-1.
REQ-016 START end: if rxs=0, go to DATA with counter BIT_TIME-1 and bit index 0; if rxs=1, treat as a glitch and return to IDLE with no output change.
REQ-017 DATA: at each phase end, shift rxs into the shift register LSB-first and reload BIT_TIME-1; after the 8th bit, go to STOP with counter BIT_TIME-1.
REQ-018 STOP end with rxs=1: latch the shift register into data, set dr in the same edge, go to IDLE.
REQ-019 STOP end with rxs=0: pulse frame_err for exactly 1 cycle, leave data and dr unchanged, go to WAIT_HIGH.
REQ-020 WAIT_HIGH: stay until rxs=1, then go to IDLE.
REQ-021 Latency: dr SHALL rise in cycle t+1+HALF+9*BIT_TIME, with t as in REQ-015.
REQ-022 go while dr=1 SHALL clear dr and overrun on the next edge.
REQ-023 go while dr=0 SHALL have no effect.
REQ-024 Byte completion while dr=1 without go in the same cycle: discard the new byte, keep data, set overrun, which stays high until go.
REQ-025 Byte completion and go in the same cycle: the new byte SHALL load, dr SHALL stay 1, overrun SHALL be cleared.
REQ-026 The bit counter SHALL be wide enough to hold BIT_TIME-1 and SHALL never wrap.
REQ-027 rx activity during any non-IDLE state SHALL NOT restart the frame.

Reset
REQ-028 rst=1 SHALL, on the next edge, force state=IDLE, counter=0, bit index=0, shift=0, data=0, dr=0, frame_err=0, overrun=0, and both synchronizer flops=1.
REQ-029 rst asserted mid-frame SHALL abort the frame with no partial byte delivered; after release, the FSM SHALL wait for a new falling edge.
REQ-030 rst SHALL take priority over go and over every FSM transition.

Structure
REQ-031 BAUD_RATE SHALL be supplied from UART_BAUD_RATE in Configuration.v at the SoC level.
REQ-032 State encodings SHALL be module-local localparams; no other shared constants are needed.
REQ-033 The 2-flop synchronizer SHALL be a separate sub-module named synchronizer, with a reset value parameter.
REQ-034 uart_rx SHALL instantiate in SoC alongside the existing transmitter and be memory-mapped there.

Verification (CLK_FREQ=1_000_000, BAUD_RATE=100_000, so BIT_TIME=10, HALF=5)
REQ-035 Bench SHALL send frame 0xA5 with a valid stop bit -> data=0xA5, dr rises exactly 1+5+90 cycles after the first rxs=0 cycle, frame_err=0.
REQ-036 Bench SHALL drive rx low for 3 cycles then high -> START aborts to IDLE, dr=0, no frame_err.
REQ-037 Bench SHALL send 0x3C with stop bit=0, then hold rx low 30 cycles, then release -> one 1-cycle frame_err pulse, dr=0, FSM in WAIT_HIGH until rx=1, then the next 0x55 frame is received correctly.
REQ-038 Bench SHALL send 0x11 then 0x22 with no go -> data=0x11, overrun=1; go -> dr=0 and overrun=0 on the next edge.
REQ-039 Bench SHALL send 0x11, then pulse go exactly on the completion cycle of 0x22 -> data=0x22, dr=1, overrun=0.
REQ-040 Bench SHALL assert rst for 1 cycle during bit 4 of 0xFF -> all outputs 0, no byte delivered; the following 0x81 frame is received intact.
